// File: rtl/q_fixed_pkg.sv
// Shared fixed-point helpers for the square-root datapath: derived sizes,
// FSM state encoding and the signed saturation constant.
package q_fixed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

  function automatic int root_w(input int w, input int f);
    return (w + f + 1) / 2;
  endfunction

  function automatic int iters(input int w, input int f, input int bpc);
    return root_w(w, f) / bpc;
  endfunction

  function automatic logic [63:0] q_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/sqrt_iter_q_if.sv
// Operand/result handshake bundle for sqrt_iter_q; the engine is the slave.
interface sqrt_iter_q_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sqrt_out;
  logic         neg;
  logic         sat;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, sqrt_out, neg, sat
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, sqrt_out, neg, sat
  );
endinterface

// File: rtl/sqrt_step.sv
// One combinational restoring digit step: consumes the top two radicand bits
// and resolves one root bit.
module sqrt_step #(
  parameter int ROOT_W = 28
) (
  input  logic [2*ROOT_W-1:0] rad_in,
  input  logic [ROOT_W:0]     rem_in,
  input  logic [ROOT_W-1:0]   root_in,
  output logic [2*ROOT_W-1:0] rad_out,
  output logic [ROOT_W:0]     rem_out,
  output logic [ROOT_W-1:0]   root_out
);
  localparam int RAD_W = 2 * ROOT_W;
  localparam int REM_W = ROOT_W + 1;
  localparam int TW    = ROOT_W + 4;

  logic [TW-1:0] shifted;
  logic [TW-1:0] divisor;
  logic [TW-1:0] trial;
  logic          unused_bits;

  // Trial subtraction of (root<<2 | 01) from the extended remainder; restore on borrow.
  always_comb begin
    shifted = {1'b0, rem_in, rad_in[RAD_W-1 -: 2]};
    divisor = {2'b00, root_in, 2'b01};
    trial   = shifted - divisor;
    rad_out = {rad_in[RAD_W-3:0], 2'b00};
    if (!trial[TW-1]) begin
      rem_out  = trial[REM_W-1:0];
      root_out = {root_in[ROOT_W-2:0], 1'b1};
    end else begin
      rem_out  = shifted[REM_W-1:0];
      root_out = {root_in[ROOT_W-2:0], 1'b0};
    end
  end

  // The remainder never exceeds 2*root, so these high bits carry no information.
  assign unused_bits = ^{root_in[ROOT_W-1], trial[TW-2:REM_W], shifted[TW-1:REM_W]};

endmodule

// File: rtl/sqrt_iter_q.sv
// Iterative restoring square root in QW-F.F, BPC root bits per clock,
// with valid/ready on both sides, optional round-to-nearest and neg/sat flags.
module sqrt_iter_q
  import q_fixed_pkg::*;
#(
  parameter int W     = 32,
  parameter int F     = 24,
  parameter int BPC   = 1,
  parameter int ROUND = 0
) (
  input logic          clk,
  input logic          rst,
  sqrt_iter_q_if.slave bus
);
  localparam int ROOT_W = root_w(W, F);
  localparam int RAD_W  = 2 * ROOT_W;
  localparam int REM_W  = ROOT_W + 1;
  localparam int EXT_W  = W + 1;
  localparam int ITERS  = iters(W, F, BPC);
  localparam int CNT_W  = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [63:0]  QMAX64 = q_max(W);
  localparam logic [W-1:0] QMAX   = QMAX64[W-1:0];

  if (F > W - 2) begin : g_bad_f
    $error("sqrt_iter_q: F must not exceed W-2");
  end
  if (!((BPC == 1) || (BPC == 2) || (BPC == 4)) || ((ROOT_W % BPC) != 0)) begin : g_bad_bpc
    $error("sqrt_iter_q: BPC must be 1, 2 or 4 and divide ROOT_W");
  end

  sqrt_state_t state_r, next_state_s;
  logic        in_ready_r, out_valid_r;
  logic        in_ready_s, out_valid_s;

  logic [RAD_W-1:0]  rad_r;
  logic [REM_W-1:0]  rem_r;
  logic [ROOT_W-1:0] root_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [W-1:0]      sqrt_out_r;
  logic              neg_r, sat_r;

  logic [RAD_W-1:0]  rad_load_s;
  logic              nonpos_s;
  logic [EXT_W-1:0]  root_ext_s, root_inc_s;
  logic [W-1:0]      result_s;
  logic              sat_s;

  logic [RAD_W-1:0]  rad_c  [0:BPC];
  logic [REM_W-1:0]  rem_c  [0:BPC];
  logic [ROOT_W-1:0] root_c [0:BPC];

  assign rad_c[0]  = rad_r;
  assign rem_c[0]  = rem_r;
  assign root_c[0] = root_r;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    sqrt_step #(.ROOT_W(ROOT_W)) u_step (
      .rad_in   (rad_c[i]),
      .rem_in   (rem_c[i]),
      .root_in  (root_c[i]),
      .rad_out  (rad_c[i+1]),
      .rem_out  (rem_c[i+1]),
      .root_out (root_c[i+1])
    );
  end

  // Radicand {a, F zeros}, left-padded to an even width; zero/negative bypass RUN.
  always_comb begin
    rad_load_s            = '0;
    rad_load_s[W+F-1:F]   = bus.a;
    nonpos_s              = bus.a[W-1] || (bus.a == '0);
  end

  // State register with the registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) next_state_s = nonpos_s ? DONE : RUN;
        else              next_state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == '0) next_state_s = DONE;
        else             next_state_s = RUN;
      end
      DONE: begin
        if (bus.out_ready) next_state_s = IDLE;
        else               next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Handshake flags follow the state being entered so they come out of flops.
  always_comb begin
    in_ready_s  = (next_state_s == IDLE);
    out_valid_s = (next_state_s == DONE);
  end

  // Final root extension, optional round-to-nearest and clamp to max positive.
  always_comb begin
    root_ext_s = {{(EXT_W-ROOT_W){1'b0}}, root_c[BPC]};
    root_inc_s = root_ext_s + EXT_W'(1);
    result_s   = root_ext_s[W-1:0];
    sat_s      = 1'b0;
    if ((ROUND != 0) && (rem_c[BPC] > {1'b0, root_c[BPC]})) begin
      if (root_inc_s > {1'b0, QMAX}) begin
        result_s = QMAX;
        sat_s    = 1'b1;
      end else begin
        result_s = root_inc_s[W-1:0];
        sat_s    = 1'b0;
      end
    end else begin
      result_s = root_ext_s[W-1:0];
      sat_s    = 1'b0;
    end
  end

  // Operand capture, per-cycle digit iteration and result registration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_r      <= '0;
      rem_r      <= '0;
      root_r     <= '0;
      cnt_r      <= '0;
      sqrt_out_r <= '0;
      neg_r      <= 1'b0;
      sat_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            rad_r  <= rad_load_s;
            rem_r  <= '0;
            root_r <= '0;
            cnt_r  <= CNT_W'(ITERS - 1);
            if (nonpos_s) begin
              sqrt_out_r <= '0;
              neg_r      <= bus.a[W-1];
              sat_r      <= 1'b0;
            end
          end
        end
        RUN: begin
          rad_r  <= rad_c[BPC];
          rem_r  <= rem_c[BPC];
          root_r <= root_c[BPC];
          cnt_r  <= cnt_r - CNT_W'(1);
          if (cnt_r == '0) begin
            sqrt_out_r <= result_s;
            neg_r      <= 1'b0;
            sat_r      <= sat_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sqrt_out  = sqrt_out_r;
  assign bus.neg       = neg_r;
  assign bus.sat       = sat_r;

endmodule

// File: tb/tb_sqrt_iter_q.sv
// Scoreboarded bench for sqrt_iter_q: directed cases on a default instance plus
// randomized traffic over BPC/W/F/ROUND variants, checked against an arithmetic model.
module tb_sqrt_iter_q;
  import q_fixed_pkg::*;

  typedef longint unsigned u64_t;
  typedef struct {
    logic [63:0] v;
    logic        neg;
    logic        sat;
    int          acc;
    int          lat;
  } exp_t;

  localparam int NCFG    = 6;
  localparam int NOPS    = 120;
  localparam int BUDGET  = 400;
  localparam int M_ITERS = iters(32, 24, 1);

  logic clk   = 1'b0;
  logic m_rst = 1'b1;
  logic r_rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cfg_w(input int g);
    return (g < 3) ? 32 : 24;
  endfunction
  function automatic int cfg_f(input int g);
    return (g < 3) ? 24 : 16;
  endfunction
  function automatic int cfg_b(input int g);
    case (g)
      0: return 2;
      1: return 4;
      2: return 1;
      3: return 1;
      4: return 2;
      default: return 4;
    endcase
  endfunction
  function automatic int cfg_r(input int g);
    return ((g == 1) || (g == 2) || (g == 4)) ? 1 : 0;
  endfunction

  function automatic longint to_signed(input logic [63:0] v, input int w);
    if (v[w-1]) return longint'(v) - (longint'(64'd1) << w);
    else        return longint'(v);
  endfunction

  // Reference: integer floor(sqrt(a * 2^F)), nearest-rounded and clamped on request.
  function automatic exp_t model(input longint a_s, input int w, input int f, input int rnd, input int it);
    exp_t e;
    u64_t rad, r, qmax;
    e.v = 64'd0; e.neg = 1'b0; e.sat = 1'b0; e.acc = 0; e.lat = 1;
    if (a_s < 0) begin
      e.neg = 1'b1;
    end else if (a_s > 0) begin
      rad = u64_t'(a_s) << f;
      r   = u64_t'($floor($sqrt(real'(rad))));
      while (r * r > rad) r--;
      while ((r + 64'd1) * (r + 64'd1) <= rad) r++;
      if ((rnd != 0) && ((rad - r * r) > r)) r++;
      qmax = (64'd1 << (w - 1)) - 64'd1;
      if (r > qmax) begin
        r = qmax;
        e.sat = 1'b1;
      end
      e.v   = r;
      e.lat = it + 1;
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [63:0] v, input logic neg, input int lat);
    exp_t e;
    e.v = v; e.neg = neg; e.sat = 1'b0; e.acc = 0; e.lat = lat;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- default instance (directed + random) ----------------
  sqrt_iter_q_if #(.W(32)) m_bus ();
  sqrt_iter_q #(.W(32), .F(24), .BPC(1), .ROUND(0)) dut (
    .clk (clk),
    .rst (m_rst),
    .bus (m_bus)
  );

  exp_t m_q[$];
  logic m_hold = 1'b0;

  initial begin : m_mon
    exp_t e;
    logic seen, nr;
    int   lat;
    seen = 1'b0;
    m_bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (m_rst) begin
        seen = 1'b0;
      end else begin
        if (m_bus.out_valid && !seen) begin
          seen = 1'b1;
          total++;
          if (m_q.size() == 0) begin
            bad++;
            $display("FAIL m_unexpected: out_valid=1 sqrt_out=%h, required no result pending", m_bus.sqrt_out);
          end else begin
            e = m_q[0];
            if ({m_bus.sqrt_out, m_bus.neg, m_bus.sat} !== {e.v[31:0], e.neg, e.sat}) begin
              bad++;
              $display("FAIL m_result: sqrt_out=%h neg=%b sat=%b required %h/%b/%b",
                       m_bus.sqrt_out, m_bus.neg, m_bus.sat, e.v[31:0], e.neg, e.sat);
            end
            lat = cyc - e.acc + 1;
            total++;
            if (lat != e.lat) begin
              bad++;
              $display("FAIL m_latency: actual=%0d required=%0d", lat, e.lat);
            end
          end
        end
        nr = !m_hold && ($urandom_range(0, 3) != 0);
        if (m_bus.out_valid && nr) begin
          if (m_q.size() > 0) void'(m_q.pop_front());
          seen = 1'b0;
        end
        m_bus.out_ready = nr;
      end
    end
  end

  task automatic m_send(input logic [31:0] av, input exp_t e_in);
    exp_t e;
    int k;
    k = 0;
    while (!m_bus.in_ready && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!m_bus.in_ready) begin
      bad++;
      $display("FAIL m_accept_timeout: in_ready=%b required 1", m_bus.in_ready);
    end else begin
      e = e_in;
      e.acc = cyc + 1;
      m_bus.a = av;
      m_bus.in_valid = 1'b1;
      m_q.push_back(e);
      @(negedge clk);
      m_bus.in_valid = 1'b0;
    end
  endtask

  task automatic m_drain();
    int k;
    k = 0;
    while ((m_q.size() != 0 || m_bus.out_valid) && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= BUDGET) begin
      bad++;
      $display("FAIL m_drain_timeout: pending=%0d required 0", m_q.size());
    end
  endtask

  // ---------------- random variants ----------------
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int GW = cfg_w(g);
    localparam int GF = cfg_f(g);
    localparam int GB = cfg_b(g);
    localparam int GR = cfg_r(g);
    localparam int GI = iters(GW, GF, GB);

    sqrt_iter_q_if #(.W(GW)) bus ();
    sqrt_iter_q #(.W(GW), .F(GF), .BPC(GB), .ROUND(GR)) u_dut (
      .clk (clk),
      .rst (r_rst),
      .bus (bus)
    );

    exp_t q[$];

    initial begin : drv
      logic [GW-1:0] av;
      exp_t e;
      int k;
      bus.in_valid = 1'b0;
      bus.a = '0;
      @(negedge clk);
      while (r_rst) @(negedge clk);
      for (int i = 0; i < NOPS; i++) begin
        k = 0;
        while (!bus.in_ready && k < BUDGET) begin
          @(negedge clk);
          k++;
        end
        total++;
        if (!bus.in_ready) begin
          bad++;
          $display("FAIL cfg%0d_accept_timeout: in_ready=%b required 1", g, bus.in_ready);
          break;
        end
        av = GW'($urandom);
        av[GW-1] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0) av = av >> $urandom_range(0, GW - 1);
        e = model(to_signed(64'(av), GW), GW, GF, GR, GI);
        if ((GW == 32) && (i == 0)) begin
          av = GW'(32'h02000000);
          e  = mk(64'h016A09E6, 1'b0, GI + 1);
        end
        e.acc = cyc + 1;
        bus.a = av;
        bus.in_valid = 1'b1;
        q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      k = 0;
      while ((q.size() != 0 || bus.out_valid) && k < BUDGET) begin
        @(negedge clk);
        k++;
      end
      total++;
      if (k >= BUDGET) begin
        bad++;
        $display("FAIL cfg%0d_drain_timeout: pending=%0d required 0", g, q.size());
      end
      n_done++;
    end

    initial begin : mon
      exp_t e;
      logic seen, nr;
      int   lat;
      seen = 1'b0;
      bus.out_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (!r_rst) begin
          if (bus.out_valid && !seen) begin
            seen = 1'b1;
            total++;
            if (q.size() == 0) begin
              bad++;
              $display("FAIL cfg%0d_unexpected: sqrt_out=%h, required no result pending", g, bus.sqrt_out);
            end else begin
              e = q[0];
              if ({bus.sqrt_out, bus.neg, bus.sat} !== {e.v[GW-1:0], e.neg, e.sat}) begin
                bad++;
                $display("FAIL cfg%0d_result: sqrt_out=%h neg=%b sat=%b required %h/%b/%b",
                         g, bus.sqrt_out, bus.neg, bus.sat, e.v[GW-1:0], e.neg, e.sat);
              end
              lat = cyc - e.acc + 1;
              total++;
              if (lat != e.lat) begin
                bad++;
                $display("FAIL cfg%0d_latency: actual=%0d required=%0d", g, lat, e.lat);
              end
            end
          end
          nr = ($urandom_range(0, 3) != 0);
          if (bus.out_valid && nr) begin
            if (q.size() > 0) void'(q.pop_front());
            seen = 1'b0;
          end
          bus.out_ready = nr;
        end
      end
    end
  end

  // ---------------- directed sequence on the default instance ----------------
  initial begin : main
    logic [31:0] av;
    int k;
    m_bus.in_valid = 1'b0;
    m_bus.a = '0;
    repeat (3) @(negedge clk);
    m_rst = 1'b0;
    r_rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  64'(m_bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(m_bus.out_valid), 64'd0);
    chk("rst_sqrt_out",  64'(m_bus.sqrt_out),  64'd0);
    chk("rst_neg",       64'(m_bus.neg),       64'd0);
    chk("rst_sat",       64'(m_bus.sat),       64'd0);

    m_send(32'h04000000, mk(64'h02000000, 1'b0, 29)); m_drain();
    m_send(32'h00400000, mk(64'h00800000, 1'b0, 29)); m_drain();
    m_send(32'h02000000, mk(64'h016A09E6, 1'b0, 29)); m_drain();
    m_send(32'h7FFFFFFF, mk(64'h0B504F33, 1'b0, 29)); m_drain();
    m_send(32'hFF000000, mk(64'h0,        1'b1, 1));  m_drain();
    m_send(32'h00000000, mk(64'h0,        1'b0, 1));  m_drain();

    // Backpressure: result frozen, in_valid ignored, then exactly one handshake.
    m_hold = 1'b1;
    m_send(32'h04000000, mk(64'h02000000, 1'b0, 29));
    k = 0;
    while (!m_bus.out_valid && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    chk("bp_reach_done", 64'(m_bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        m_bus.a = 32'h01000000;
        m_bus.in_valid = 1'b1;
      end else begin
        m_bus.in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_hold", {29'd0, m_bus.out_valid, m_bus.in_ready, m_bus.neg, m_bus.sqrt_out},
                     {29'd0, 1'b1, 1'b0, 1'b0, 32'h02000000});
    end
    m_bus.in_valid = 1'b0;
    m_hold = 1'b0;
    m_drain();
    chk("bp_idle", {62'd0, m_bus.in_ready, m_bus.out_valid}, {62'd0, 1'b1, 1'b0});

    // Reset in the middle of RUN abandons the operation.
    m_send(32'h04000000, mk(64'h02000000, 1'b0, 29));
    repeat (11) @(negedge clk);
    m_rst = 1'b1;
    m_q.delete();
    @(negedge clk);
    chk("rst_mid", {62'd0, m_bus.in_ready, m_bus.out_valid}, {62'd0, 1'b1, 1'b0});
    m_rst = 1'b0;
    repeat (40) @(negedge clk);
    m_send(32'h04000000, mk(64'h02000000, 1'b0, 29)); m_drain();

    for (int i = 0; i < 100; i++) begin
      av = $urandom;
      av[31] = 1'b0;
      if ($urandom_range(0, 2) == 0) av = av >> $urandom_range(0, 31);
      m_send(av, model(to_signed(64'(av), 32), 32, 24, 0, M_ITERS));
    end
    m_drain();

    k = 0;
    while (n_done < NCFG && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("all_cfg_done", 64'(n_done), 64'(NCFG));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
